// File: rtl/rf_wb_sched_if.sv
// Bundle of the decode-issue, write-back request and regf write-port signals
// around the write-back scheduler.
//   slave  : scheduler side (consumes issue/wb requests, drives stall, grants,
//            regf write port, scoreboard and idle)
//   master : environment side (decode, execution units, regf)
interface rf_wb_sched_if #(
   parameter int NSRC = 3,
   parameter int XLEN = 32
);
   logic                 issue_valid;
   logic [4:0]           issue_rs1;
   logic [4:0]           issue_rs2;
   logic                 issue_rs1_en;
   logic                 issue_rs2_en;
   logic [4:0]           issue_rd;
   logic                 issue_rd_en;
   logic                 issue_stall;
   logic [NSRC-1:0]      wb_valid;
   logic [NSRC*5-1:0]    wb_addr;
   logic [NSRC*XLEN-1:0] wb_data;
   logic [NSRC-1:0]      wb_ready;
   logic                 w_enable;
   logic [4:0]           w_addr;
   logic [XLEN-1:0]      w_data;
   logic [31:0]          busy;
   logic                 idle;

   modport slave (
      input  issue_valid, issue_rs1, issue_rs2, issue_rs1_en, issue_rs2_en,
             issue_rd, issue_rd_en, wb_valid, wb_addr, wb_data,
      output issue_stall, wb_ready, w_enable, w_addr, w_data, busy, idle
   );

   modport master (
      output issue_valid, issue_rs1, issue_rs2, issue_rs1_en, issue_rs2_en,
             issue_rd, issue_rd_en, wb_valid, wb_addr, wb_data,
      input  issue_stall, wb_ready, w_enable, w_addr, w_data, busy, idle
   );
endinterface

// File: rtl/rf_wb_sched.sv
// Register-file write-back scheduler and scoreboard.
// Arbitrates the single regf write port round-robin among NSRC execution
// units (0 = ALU, 1 = MEM, 2 = FPU) and stalls issue on RAW/WAW hazards
// against writes still in flight.
// Ports:
//   clk  : clock
//   rstn : asynchronous active-low reset
//   bus  : rf_wb_sched_if.slave (issue, write-back requests/grants,
//          regf write port, busy scoreboard, idle)
module rf_wb_sched #(
   parameter int NSRC = 3,
   parameter int XLEN = 32
) (
   input logic          clk,
   input logic          rstn,
   rf_wb_sched_if.slave bus
);
   localparam int LW = (NSRC > 1) ? $clog2(NSRC) : 1;

   logic [31:0]     busy_q, busy_d;
   logic [4:0]      count_q, count_d;
   logic [LW-1:0]   last_q, last_d;

   logic [NSRC-1:0] grant;
   logic [LW-1:0]   gidx;
   logic            gany;
   logic [4:0]      waddr;
   logic [XLEN-1:0] wdata;
   logic            stall, accept, clr, dec;
   logic [31:0]     set_mask, clr_mask;

   // Round-robin search starting one past the last winner. Held reset
   // forces no grant so nothing is consumed while tracking is cleared.
   always_comb begin
      logic [LW-1:0] cand;
      grant = '0;
      gidx  = '0;
      gany  = 1'b0;
      cand  = '0;
      for (int k = 1; k <= NSRC; k++) begin
         cand = LW'((int'(last_q) + k) % NSRC);
         if (!gany && rstn && bus.wb_valid[cand]) begin
            grant[cand] = 1'b1;
            gidx        = cand;
            gany        = 1'b1;
         end
      end
   end

   always_comb begin
      waddr = '0;
      wdata = '0;
      if (gany) begin
         waddr = bus.wb_addr[int'(gidx)*5 +: 5];
         wdata = bus.wb_data[int'(gidx)*XLEN +: XLEN];
      end
   end

   assign stall = bus.issue_valid &
                  ((bus.issue_rs1_en & busy_q[bus.issue_rs1]) |
                   (bus.issue_rs2_en & busy_q[bus.issue_rs2]) |
                   (bus.issue_rd_en  & busy_q[bus.issue_rd])  |
                   (count_q == 5'd31));

   assign accept = bus.issue_valid & ~stall & bus.issue_rd_en & (bus.issue_rd != 5'd0);
   assign clr    = gany & (waddr != 5'd0);
   // Only retire writes that were actually tracked; a stray result after a
   // mid-flight reset must not underflow the counter and lock up issue.
   assign dec    = clr & busy_q[waddr];

   always_comb begin
      set_mask = '0;
      clr_mask = '0;
      if (accept) set_mask = 32'd1 << bus.issue_rd;
      if (clr)    clr_mask = 32'd1 << waddr;
      busy_d = (busy_q | set_mask) & ~clr_mask & ~32'd1;

      count_d = count_q;
      if (accept && !dec)      count_d = count_q + 5'd1;
      else if (!accept && dec) count_d = count_q - 5'd1;

      last_d = gany ? gidx : last_q;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         busy_q  <= '0;
         count_q <= '0;
         last_q  <= LW'(NSRC - 1);
      end else begin
         busy_q  <= busy_d;
         count_q <= count_d;
         last_q  <= last_d;
      end
   end

   assign bus.issue_stall = stall;
   assign bus.wb_ready    = grant;
   assign bus.w_enable    = clr;
   assign bus.w_addr      = waddr;
   assign bus.w_data      = wdata;
   assign bus.busy        = busy_q;
   assign bus.idle        = (count_q == 5'd0);

   // Issue to a busy rd stalls, so one index is never set and cleared together.
   a_no_set_clr: assert property (@(posedge clk) disable iff (!rstn)
      !(accept && clr && (bus.issue_rd == waddr)));

   // A result for a register with no write in flight is a producer error.
   a_wb_tracked: assert property (@(posedge clk) disable iff (!rstn)
      !(clr && !busy_q[waddr]));
endmodule

// File: tb/tb_rf_wb_sched.sv
module tb_rf_wb_sched;
   localparam int NSRC = 3;
   localparam int XLEN = 32;

   typedef struct packed {
      logic [4:0]  a;
      logic [31:0] d;
   } wr_t;

   logic clk;
   logic rstn;
   int   checks;
   int   failures;
   wr_t  q[$];

   rf_wb_sched_if #(.NSRC(NSRC), .XLEN(XLEN)) bus ();

   rf_wb_sched #(.NSRC(NSRC), .XLEN(XLEN)) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s obs=0x%0h exp=0x%0h", tag, obs, exp);
      end
   endtask

   // Compare any regf write against the scoreboard queue.
   task automatic wb_mon();
      wr_t e;
      if (bus.w_enable === 1'b1) begin
         checks++;
         assert (q.size() != 0) else begin
            failures++;
            $error("FAIL wr_unexpected obs_addr=%0d exp=none", bus.w_addr);
         end
         if (q.size() != 0) begin
            e = q.pop_front();
            chk("wr_addr", 64'(bus.w_addr), 64'(e.a));
            chk("wr_data", 64'(bus.w_data), 64'(e.d));
         end
      end
   endtask

   // One cycle: sample at negedge, advance past posedge, producers drop
   // any request that was granted.
   task automatic tick();
      logic [NSRC-1:0] rdy;
      @(negedge clk);
      wb_mon();
      rdy = bus.wb_ready;
      @(posedge clk);
      #1;
      bus.wb_valid = bus.wb_valid & ~rdy;
   endtask

   task automatic issue(input logic v, input logic [4:0] rs1, input logic rs1_en,
                        input logic [4:0] rs2, input logic rs2_en,
                        input logic [4:0] rd, input logic rd_en);
      bus.issue_valid  = v;
      bus.issue_rs1    = rs1;
      bus.issue_rs1_en = rs1_en;
      bus.issue_rs2    = rs2;
      bus.issue_rs2_en = rs2_en;
      bus.issue_rd     = rd;
      bus.issue_rd_en  = rd_en;
   endtask

   task automatic present(input int s, input logic [4:0] a, input logic [31:0] d);
      wr_t e;
      bus.wb_valid[s]        = 1'b1;
      bus.wb_addr[s*5 +: 5]  = a;
      bus.wb_data[s*32 +: 32] = d;
      if (a != 5'd0) begin
         e.a = a;
         e.d = d;
         q.push_back(e);
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rstn     = 1'b0;
      issue(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
      bus.wb_valid = '1;
      bus.wb_addr  = '0;
      bus.wb_data  = '0;

      // Reset held with all sources requesting.
      repeat (3) begin
         #1;
         chk("rst_ready", 64'(bus.wb_ready), 64'd0);
         chk("rst_busy",  64'(bus.busy),     64'd0);
         chk("rst_idle",  64'(bus.idle),     64'd1);
         chk("rst_wen",   64'(bus.w_enable), 64'd0);
         tick();
      end
      rstn = 1'b1;
      #1;
      chk("rel_ready", 64'(bus.wb_ready), 64'b001);
      bus.wb_valid = '0;
      tick();

      // Round-robin: make x1..x3 busy, then all three return together.
      for (int i = 1; i <= 3; i++) begin
         issue(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'(i), 1'b1);
         #1;
         chk("rr_issue_stall", 64'(bus.issue_stall), 64'd0);
         tick();
      end
      issue(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
      #1;
      chk("rr_busy", 64'(bus.busy), 64'h0000_000E);
      chk("rr_idle0", 64'(bus.idle), 64'd0);
      present(0, 5'd1, 32'h1111_1111);
      present(1, 5'd2, 32'h2222_2222);
      present(2, 5'd3, 32'h3333_3333);
      #1;
      chk("rr_g0", 64'(bus.wb_ready), 64'b001);
      tick();
      #1;
      chk("rr_g1", 64'(bus.wb_ready), 64'b010);
      tick();
      #1;
      chk("rr_g2", 64'(bus.wb_ready), 64'b100);
      chk("rr_idle_pre", 64'(bus.idle), 64'd0);
      tick();
      #1;
      chk("rr_idle", 64'(bus.idle), 64'd1);
      chk("rr_busy_clr", 64'(bus.busy), 64'd0);

      // RAW on x5 produced by MEM.
      issue(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1);
      #1;
      chk("raw_c0_stall", 64'(bus.issue_stall), 64'd0);
      tick();
      issue(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
      #1;
      chk("raw_busy5", 64'(bus.busy[5]), 64'd1);
      for (int c = 1; c <= 3; c++) begin
         chk("raw_stall", 64'(bus.issue_stall), 64'd1);
         tick();
         #1;
      end
      present(1, 5'd5, 32'hDEAD_BEEF);
      #1;
      chk("raw_c4_ready", 64'(bus.wb_ready), 64'b010);
      chk("raw_c4_wen",   64'(bus.w_enable), 64'd1);
      chk("raw_c4_stall", 64'(bus.issue_stall), 64'd1);
      tick();
      #1;
      chk("raw_c5_stall", 64'(bus.issue_stall), 64'd0);
      chk("raw_c5_busy5", 64'(bus.busy[5]), 64'd0);
      tick();
      issue(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
      #1;
      chk("raw_idle", 64'(bus.idle), 64'd1);

      // WAW on x7: FPU producer, then ALU producer.
      issue(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1);
      #1;
      chk("waw_first", 64'(bus.issue_stall), 64'd0);
      tick();
      #1;
      chk("waw_second", 64'(bus.issue_stall), 64'd1);
      tick();
      #1;
      chk("waw_hold", 64'(bus.issue_stall), 64'd1);
      present(2, 5'd7, 32'h7777_0002);
      #1;
      chk("waw_g_fpu", 64'(bus.wb_ready), 64'b100);
      chk("waw_g_stall", 64'(bus.issue_stall), 64'd1);
      tick();
      #1;
      chk("waw_release", 64'(bus.issue_stall), 64'd0);
      tick();
      issue(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
      #1;
      chk("waw_busy7", 64'(bus.busy[7]), 64'd1);
      present(0, 5'd7, 32'h7777_0000);
      #1;
      chk("waw_g_alu", 64'(bus.wb_ready), 64'b001);
      tick();
      #1;
      chk("waw_idle", 64'(bus.idle), 64'd1);

      // x0 destination.
      issue(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1);
      #1;
      chk("x0_issue", 64'(bus.issue_stall), 64'd0);
      tick();
      issue(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
      #1;
      chk("x0_idle", 64'(bus.idle), 64'd1);
      chk("x0_busy", 64'(bus.busy), 64'd0);
      present(0, 5'd0, 32'hFFFF_FFFF);
      #1;
      chk("x0_ready", 64'(bus.wb_ready), 64'b001);
      chk("x0_wen",   64'(bus.w_enable), 64'd0);
      tick();
      issue(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
      #1;
      chk("x0_idle2", 64'(bus.idle), 64'd1);
      chk("x0_rs1", 64'(bus.issue_stall), 64'd0);
      tick();

      // Counter saturation: 31 in flight, then one more issue.
      for (int i = 1; i <= 31; i++) begin
         issue(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'(i), 1'b1);
         #1;
         chk("sat_fill", 64'(bus.issue_stall), 64'd0);
         tick();
      end
      issue(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
      #1;
      chk("sat_busy", 64'(bus.busy), 64'hFFFF_FFFE);
      chk("sat_stall", 64'(bus.issue_stall), 64'd1);
      present(1, 5'd31, 32'h0000_001F);
      #1;
      chk("sat_g_ready", 64'(bus.wb_ready), 64'b010);
      chk("sat_g_stall", 64'(bus.issue_stall), 64'd1);
      tick();
      #1;
      chk("sat_release", 64'(bus.issue_stall), 64'd0);
      tick();
      issue(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
      for (int i = 1; i <= 30; i++) begin
         present(0, 5'(i), 32'hA000_0000 | 32'(i));
         tick();
      end
      #1;
      chk("sat_drain_idle", 64'(bus.idle), 64'd1);
      chk("sat_drain_busy", 64'(bus.busy), 64'd0);
      chk("sb_empty", 64'(q.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/rf_wb_sched.md
# rf_wb_sched

Register-file write-back scheduler and scoreboard for the integer core. It sits between the execution units (ALU, memory, FPU-to-integer) and the single write port of the `regf` register file. It arbitrates that port round-robin and tracks which architectural registers have writes in flight. It stalls issue on RAW and WAW hazards until the pending write has been committed.

## Interface
Parameters:
- `NSRC`, 3: number of write-back requesters; index 0 = ALU, 1 = MEM, 2 = FPU.
- `XLEN`, 32: data width.

Ports:
- `clk` in 1: clock. One clock domain.
- `rstn` in 1: reset, asynchronous, active-low.
- `issue_valid` in 1: decode presents an instruction.
- `issue_rs1`, `issue_rs2` in 5 each: source register indices.
- `issue_rs1_en`, `issue_rs2_en` in 1 each: the source is actually read.
- `issue_rd` in 5: destination index.
- `issue_rd_en` in 1: the instruction writes `rd`.
- `issue_stall` out 1: combinational; the instruction must be held this cycle.
- `wb_valid` in NSRC: unit i holds a result.
- `wb_addr` in NSRC×5: packed destination indices.
- `wb_data` in NSRC×XLEN: packed result data.
- `wb_ready` out NSRC: one-hot grant; the result is consumed at this edge.
- `w_enable` out 1: to the `regf` write port.
- `w_addr` out 5: to the `regf` write port.
- `w_data` out XLEN: to the `regf` write port.
- `busy` out 32: registered scoreboard; bit 0 is always 0.
- `idle` out 1: high when no write is outstanding.

## Operation
- Scoreboard `busy[31:1]`:
  - Set at the clock edge where `issue_valid & ~issue_stall & issue_rd_en & rd!=0`.
  - Cleared at the edge where a grant targets that index.
- `issue_stall` uses only the registered `busy`. It asserts when `issue_valid` and any of these holds:
  - `issue_rs1_en & busy[rs1]`
  - `issue_rs2_en & busy[rs2]`
  - `issue_rd_en & busy[rd]` (WAW)
  - the outstanding counter is at maximum (31).
- Same-cycle set and clear of one index cannot occur, because issue to a busy rd stalls. An RTL assertion guards this.
- Grant arbiter is round-robin over `wb_valid`:
  - Pointer `last` (2 bits) holds the most recently granted source.
  - Search order is `last+1`, `last+2`, … modulo NSRC.
  - `last` updates only on a grant.
- `wb_ready` is combinational from `wb_valid` and `last`, with at most one bit set.
- Write port is combinational from the granted source:
  - `w_enable = |wb_ready & w_addr!=0`
  - `w_addr`/`w_data` come from the muxed winner; they are 0 when there is no grant.
- A write to x0 is granted and consumed, but `w_enable` stays 0. It does not touch the scoreboard or the counter.
- Outstanding counter (5 bits) tracks writes in flight:
  - Increments on an accepted issue with rd!=0.
  - Decrements on a grant with addr!=0.
  - Both in the same cycle leave it unchanged.
  - `idle = (count==0)`.
- Producers hold `wb_valid`/`wb_addr`/`wb_data` stable until `wb_ready`.
- A `wb_valid` whose addr is not busy is a protocol error. It is still written and flagged by a simulation assertion.

## Timing
- Reset (asynchronous, `rstn` low) sets `busy`=0, count=0, and `last`=NSRC-1, so the first grant goes to ALU. While reset is held, `wb_ready`=0, `w_enable`=0 and `idle`=1.
- Reset mid-operation discards all in-flight tracking. Results presented after reset are treated as protocol errors.
- Write latency is 0 cycles: the grant and the regf write happen at the same edge. `regf` reads are registered, so a dependent instruction issued the cycle after the grant reads the new value.
- Issue-to-stall-release:
  - The earliest release is the cycle after the producing write is granted; the busy bit clears at the grant edge.
  - There is no bypass.
- Under continuous contention each source waits at most NSRC-1 grant cycles.

## Test plan
- **Reset:** hold `rstn`=0 for 3 cycles with `wb_valid`=3'b111 → `wb_ready`=0, `busy`=0, `idle`=1. On the first cycle after release, `wb_ready`=3'b001.
- **RAW stall:** issue rd=5 (MEM) at cycle 0; at cycle 1 issue rs1=5 → `issue_stall`=1. At cycle 4 MEM returns addr=5, data=0xDEADBEEF, granted with `w_enable`=1 → stall drops at cycle 5 and `busy[5]`=0.
- **Round-robin:** all three sources valid with addresses 1, 2, 3 (each busy) → grants arrive in order ALU, MEM, FPU over cycles 0-2. `idle` rises at cycle 3.
- **WAW:** issue rd=7 (FPU), then rd=7 (ALU) → the second issue stalls until the FPU write of 7 is granted.
- **x0:** issue rd=0, then ALU returns addr=0 → `wb_ready[0]`=1, `w_enable`=0, count unchanged, no stall for a later rs1=0.
- **Counter saturation:** 31 issues to rd=1..31 without grants → the 32nd issue stalls regardless of its registers, and the stall clears after one grant.
